// File: rtl/mem_initiator.sv
// Single-outstanding memory bus initiator: takes one command, runs one bus cycle
// with optional timeout, then holds the response until consumed.
module mem_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StBus, StRsp} state_e;

  state_e            r_state, w_state_d;
  logic              r_cmd_ready, w_cmd_ready_d;
  logic              r_busy, w_busy_d;
  logic              r_mem_valid, w_mem_valid_d;
  logic [31:0]       r_mem_addr, w_mem_addr_d;
  logic [31:0]       r_mem_wdata, w_mem_wdata_d;
  logic [3:0]        r_mem_wstrb, w_mem_wstrb_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [31:0]       r_rsp_rdata, w_rsp_rdata_d;
  logic              r_rsp_err, w_rsp_err_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              w_timeout;

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CntLast);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cmd_ready <= w_cmd_ready_d;
      r_busy      <= w_busy_d;
      r_mem_valid <= w_mem_valid_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_mem_wstrb <= w_mem_wstrb_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rsp_err   <= w_rsp_err_d;
      r_cnt       <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_mem_valid_d = r_mem_valid;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_mem_wstrb_d = r_mem_wstrb;
    w_rsp_valid_d = r_rsp_valid;
    w_rsp_rdata_d = r_rsp_rdata;
    w_rsp_err_d   = r_rsp_err;
    w_cnt_d       = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_d     = StBus;
          w_mem_valid_d = 1'b1;
          w_mem_addr_d  = cmd_addr;
          w_mem_wdata_d = cmd_wdata;
          w_mem_wstrb_d = cmd_wstrb;
          w_cnt_d       = '0;
        end
      end
      StBus: begin
        // A ready coinciding with the timeout wins as a normal completion.
        if (mem_ready) begin
          w_state_d     = StRsp;
          w_mem_valid_d = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_rsp_rdata_d = (r_mem_wstrb == 4'b0000) ? mem_rdata : 32'h0;
          w_rsp_err_d   = 1'b0;
        end else if (w_timeout) begin
          w_state_d     = StRsp;
          w_mem_valid_d = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_rsp_rdata_d = 32'h0;
          w_rsp_err_d   = 1'b1;
        end else if (r_cnt != {CntW{1'b1}}) begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          w_state_d     = StIdle;
          w_rsp_valid_d = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_cmd_ready_d = (w_state_d == StIdle);
    w_busy_d      = (w_state_d != StIdle);
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator: directed commands push expected responses,
// a negedge monitor pops on every response handshake and tracks mem_valid runs.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   run_len  = 0;
  int   last_run = 0;
  int   rises    = 0;
  logic prev_mv  = 1'b0;
  logic rdy_en;

  mem_initiator #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Responder registers ready from valid, so ready lingers one cycle after valid drops.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) mem_ready <= 1'b0;
    else         mem_ready <= rdy_en & mem_valid;
  end

  always_comb begin
    mem_rdata = (mem_addr == 32'h10) ? 32'hA5A5_0001 : {mem_addr[15:0], 16'hBEEF};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_valid) begin
      run_len++;
      if (!prev_mv) rises++;
    end else if (prev_mv) begin
      last_run = run_len;
      run_len  = 0;
    end
    prev_mv = mem_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input exp_t e);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || !cmd_ready) && n < 30) begin
      tick();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; rdy_en = 1'b1;
    #23;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Read, ready one cycle after valid.
    rsp_ready = 1'b1;
    issue(32'h10, 32'h0, 4'b0000, '{rdata: 32'hA5A5_0001, err: 1'b0});
    chk("rd_mem_valid", 32'(mem_valid), 32'd1);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rd_busy", 32'(busy), 32'd1);
    wait_idle("rd_done");
    chk("rd_valid_cycles", 32'(last_run), 32'd2);

    // Write: strobes and data stable while valid, zero read data back.
    issue(32'h0, 32'h1, 4'b0001, '{rdata: 32'h0, err: 1'b0});
    chk("wr_wstrb", 32'(mem_wstrb), 32'd1);
    chk("wr_wdata", mem_wdata, 32'h1);
    tick();
    chk("wr_valid_hold", 32'(mem_valid), 32'd1);
    chk("wr_wstrb_hold", 32'(mem_wstrb), 32'd1);
    chk("wr_wdata_hold", mem_wdata, 32'h1);
    wait_idle("wr_done");

    // Timeout with ready never asserted.
    rdy_en = 1'b0;
    issue(32'h40, 32'h0, 4'b0000, '{rdata: 32'h0, err: 1'b1});
    wait_idle("to_done");
    chk("to_valid_cycles", 32'(last_run), 32'd4);

    // Ready lands on the timeout cycle: normal completion.
    issue(32'h50, 32'h0, 4'b0000, '{rdata: 32'h0050_BEEF, err: 1'b0});
    tick();
    tick();
    rdy_en = 1'b1;
    wait_idle("to_race_done");
    chk("to_race_cycles", 32'(last_run), 32'd4);

    // Back-to-back with held cmd_valid and a stale-ready responder.
    r0 = rises;
    sb.push_back('{rdata: 32'h0020_BEEF, err: 1'b0});
    sb.push_back('{rdata: 32'h0030_BEEF, err: 1'b0});
    cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_wstrb = 4'b0000;
    tick();
    cmd_addr = 32'h30;
    repeat (4) tick();
    cmd_valid = 1'b0;
    chk("b2b_second_addr", mem_addr, 32'h30);
    chk("b2b_second_valid", 32'(mem_valid), 32'd1);
    tick();
    chk("b2b_no_false_done", 32'(mem_valid), 32'd1);
    wait_idle("b2b_done");
    chk("b2b_rises", 32'(rises - r0), 32'd2);
    chk("b2b_valid_cycles", 32'(last_run), 32'd2);

    // Backpressure on the response.
    rsp_ready = 1'b0;
    r0 = rises;
    issue(32'h60, 32'h0, 4'b0000, '{rdata: 32'h0060_BEEF, err: 1'b0});
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h0060_BEEF);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_mem_valid", 32'(mem_valid), 32'd0);
      tick();
    end
    chk("bp_rises", 32'(rises - r0), 32'd1);
    rsp_ready = 1'b1;
    wait_idle("bp_done");

    // Reset during BUS: transaction discarded, no response.
    rdy_en = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h80; cmd_wstrb = 4'b0000;
    tick();
    cmd_valid = 1'b0;
    chk("mr_in_bus", 32'(mem_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_valid_async_drop", 32'(mem_valid), 32'd0);
    chk("mr_busy_drop", 32'(busy), 32'd0);
    tick();
    tick();
    chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
    resetn = 1'b1;
    rdy_en = 1'b1;
    tick();
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mr_no_rsp_after", 32'(rsp_valid), 32'd0);
    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum BUS-state cycles to wait for mem_ready; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: a command is accepted on cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_addr, input, 32 bits: byte address of the command.
REQ-007 SHALL have port cmd_wdata, input, 32 bits: write data.
REQ-008 SHALL have port cmd_wstrb, input, 4 bits: byte strobes; 4'b0000 means read, any nonzero value means write.
REQ-009 SHALL have port rsp_valid, output, 1 bit: a response is held.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the response is consumed on rsp_valid & rsp_ready.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: read data captured from the bus.
REQ-012 SHALL have port rsp_err, output, 1 bit: the transaction timed out.
REQ-013 SHALL have port mem_valid, output, 1 bit: bus request towards the responder.
REQ-014 SHALL have port mem_ready, input, 1 bit: responder completion.
REQ-015 SHALL have port mem_addr, output, 32 bits: bus address.
REQ-016 SHALL have port mem_wdata, output, 32 bits: bus write data.
REQ-017 SHALL have port mem_wstrb, output, 4 bits: bus byte strobes.
REQ-018 SHALL have port mem_rdata, input, 32 bits: responder read data.
REQ-019 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-020 SHALL implement three states: IDLE, BUS and RSP.
REQ-021 SHALL drive cmd_ready = 1 only in IDLE; the command is accepted on cmd_valid & cmd_ready.
REQ-022 SHALL, on acceptance, register cmd_addr, cmd_wdata and cmd_wstrb onto mem_addr, mem_wdata and mem_wstrb, and move to BUS; mem_valid rises on the next edge, giving 1 cycle from acceptance to mem_valid.
REQ-023 SHALL be registered on every output, with no combinational path from any input to any output.
REQ-024 SHALL, in BUS, hold mem_valid = 1 and keep mem_addr, mem_wdata and mem_wstrb stable until completion.
REQ-025 SHALL complete a BUS cycle on mem_valid & mem_ready: capture mem_rdata into rsp_rdata for reads; set rsp_rdata = 0 for writes; set rsp_err = 0; clear mem_valid; move to RSP.
REQ-026 SHALL ignore mem_ready in IDLE and RSP, because responders register ready from valid and can leave ready high for 1 cycle after valid drops.
REQ-027 SHALL keep mem_valid low for at least 1 cycle between consecutive transactions; the RSP state guarantees this.
REQ-028 SHALL count BUS cycles with a counter cleared on entry to BUS; the counter width is sufficient for TIMEOUT and it does not wrap.
REQ-029 SHALL, when TIMEOUT != 0 and the counter reaches TIMEOUT without mem_ready: clear mem_valid, set rsp_err = 1, set rsp_rdata = 0, and move to RSP.
REQ-030 SHALL treat mem_ready arriving in the same cycle as the timeout as a normal completion, with rsp_err = 0.
REQ-031 SHALL, in RSP, hold rsp_valid = 1 with rsp_rdata and rsp_err stable until rsp_ready; on rsp_valid & rsp_ready, clear rsp_valid and return to IDLE.
REQ-032 SHALL NOT accept a new command in the cycle rsp_valid & rsp_ready occurs; cmd_ready rises on the following cycle.
REQ-033 SHALL support a minimum transaction period of 4 cycles against a responder that asserts mem_ready one cycle after mem_valid.
REQ-034 SHALL treat the address as opaque: no alignment check and no address increment.

Reset
REQ-035 SHALL, while resetn = 0, immediately and asynchronously set: state = IDLE, mem_valid = 0, rsp_valid = 0, rsp_err = 0, busy = 0, cmd_ready = 0, and mem_addr, mem_wdata, mem_wstrb, rsp_rdata and the counter all = 0.
REQ-036 SHALL drive cmd_ready = 1 on the first clock edge after resetn rises.
REQ-037 SHALL, when reset is asserted mid-transaction, drop mem_valid asynchronously, discard the transaction and produce no response.

Verification
REQ-038 SHALL be verified with a read: cmd addr = 0x00000010, wstrb = 0; responder returns mem_rdata = 0xA5A5_0001 with ready 1 cycle after valid -> mem_valid high exactly 2 cycles, then rsp_valid with rsp_rdata = 0xA5A50001 and rsp_err = 0.
REQ-039 SHALL be verified with a write: cmd addr = 0x00000000, wdata = 0x1, wstrb = 4'b0001 -> mem_wstrb = 4'b0001 and mem_wdata = 0x1 stable while mem_valid is high; the response has rsp_rdata = 0 and rsp_err = 0.
REQ-040 SHALL be verified with a timeout: TIMEOUT = 4 and mem_ready held 0 -> mem_valid is high for exactly 4 cycles, then rsp_err = 1 and rsp_rdata = 0.
REQ-041 SHALL be verified with back-to-back commands, cmd_valid held high and rsp_ready = 1, against a stale-ready responder -> the second transaction is not falsely completed, there is at least 1 cycle of mem_valid = 0 between transactions, and each response carries its own data.
REQ-042 SHALL be verified with backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stay stable, cmd_ready stays 0, and there is no new mem_valid.
REQ-043 SHALL be verified with mid-operation reset: resetn pulsed low during BUS -> mem_valid drops before the next edge, no rsp_valid appears, and cmd_ready = 1 on the first edge after release.
